// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared physical-memory address and line types
package lc3b_types;

   localparam int PMEM_ADDR_W = 16;
   localparam int PMEM_LINE_W = 128;

   typedef logic [PMEM_ADDR_W-1:0] lc3b_pmem_addr;
   typedef logic [PMEM_LINE_W-1:0] lc3b_pmem_line;

endpackage

// File: rtl/wb_entry.sv
// rtl/wb_entry.sv - single write-buffer entry (valid, address, line)
module wb_entry
   import lc3b_types::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          clear,
   input  lc3b_pmem_addr load_addr,
   input  lc3b_pmem_line load_line,
   output logic          valid,
   output lc3b_pmem_addr addr,
   output lc3b_pmem_line line
);

   logic          valid_q, valid_d;
   lc3b_pmem_addr addr_q, addr_d;
   lc3b_pmem_line line_q, line_d;

   // Load wins over clear; the controller never asserts both in one cycle.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      line_d  = line_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = load_addr;
         line_d  = load_line;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   // Entry storage; reset discards any buffered line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         line_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
      end
   end

   assign valid = valid_q;
   assign addr  = addr_q;
   assign line  = line_q;

endmodule

// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - one-entry writeback buffer between L2 and physical memory
module l2_write_buffer
   import lc3b_types::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_read,
   input  logic          mem_write,
   input  lc3b_pmem_addr mem_address,
   input  lc3b_pmem_line mem_wdata,
   output logic          mem_resp,
   output lc3b_pmem_line mem_rdata,
   output logic          pmem_read,
   output logic          pmem_write,
   output lc3b_pmem_addr pmem_address,
   output lc3b_pmem_line pmem_wdata,
   input  logic          pmem_resp,
   input  lc3b_pmem_line pmem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t        state_q, state_d;
   logic          entry_valid;
   lc3b_pmem_addr entry_addr;
   lc3b_pmem_line entry_line;
   logic          entry_load;
   logic          entry_clear;
   logic          hit;

   wb_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (entry_load),
      .clear     (entry_clear),
      .load_addr (mem_address),
      .load_line (mem_wdata),
      .valid     (entry_valid),
      .addr      (entry_addr),
      .line      (entry_line)
   );

   assign hit = entry_valid && (entry_addr == mem_address);

   // Request steering: reads beat writes beat idle drain; a pmem transaction
   // once started holds its address/data until pmem_resp.
   always_comb begin
      state_d      = state_q;
      entry_load   = 1'b0;
      entry_clear  = 1'b0;
      mem_resp     = 1'b0;
      mem_rdata    = entry_line;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = entry_addr;
      pmem_wdata   = entry_line;
      case (state_q)
         IDLE: begin
            if (mem_read) begin
               if (hit) begin
                  mem_resp = 1'b1;
               end else begin
                  state_d = READ;
               end
            end else if (mem_write) begin
               if (!entry_valid || hit) begin
                  entry_load = 1'b1;
                  mem_resp   = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else if (entry_valid) begin
               state_d = DRAIN;
            end
         end
         READ: begin
            pmem_read    = 1'b1;
            pmem_address = mem_address;
            mem_rdata    = pmem_rdata;
            mem_resp     = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            pmem_write = 1'b1;
            if (mem_read && hit) begin
               mem_resp = 1'b1;
            end
            if (pmem_resp) begin
               entry_clear = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any in-flight pmem transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb/tb_l2_write_buffer.sv - self-checking bench for l2_write_buffer
module tb_l2_write_buffer;
   import lc3b_types::*;

   localparam int LAT = 3;
   localparam int TMO = 60;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_read, mem_write;
   lc3b_pmem_addr mem_address;
   lc3b_pmem_line mem_wdata;
   logic          mem_resp;
   lc3b_pmem_line mem_rdata;
   logic          pmem_read, pmem_write;
   lc3b_pmem_addr pmem_address;
   lc3b_pmem_line pmem_wdata;
   logic          pmem_resp;
   lc3b_pmem_line pmem_rdata;

   l2_write_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_resp = 0;
   int n_pw = 0;
   int n_pr = 0;
   lc3b_pmem_addr last_pw_addr;
   lc3b_pmem_line last_pw_data;

   // pstore: contents of physical memory; arch: what the L2 should observe
   lc3b_pmem_line pstore [lc3b_pmem_addr];
   lc3b_pmem_line arch   [lc3b_pmem_addr];

   function automatic lc3b_pmem_line dflt(input lc3b_pmem_addr a);
      return {4{a, ~a}};
   endfunction

   function automatic lc3b_pmem_line p_rd(input lc3b_pmem_addr a);
      if (pstore.exists(a)) return pstore[a];
      return dflt(a);
   endfunction

   function automatic lc3b_pmem_line a_rd(input lc3b_pmem_addr a);
      if (arch.exists(a)) return arch[a];
      return dflt(a);
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Physical memory: answers any request LAT cycles after it appears.
   int cnt;
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      cnt        = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || pmem_resp) begin
            pmem_resp = 1'b0;
            cnt       = 0;
         end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == LAT) begin
               pmem_resp = 1'b1;
               if (pmem_write) pstore[pmem_address] = pmem_wdata;
               else            pmem_rdata = p_rd(pmem_address);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Per-cycle compare against the architectural model.
   logic          pv_act, pv_resp;
   logic [255:0]  pv_req;
   initial begin
      pv_act = 1'b0;
      pv_resp = 1'b0;
      pv_req = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv_act = 1'b0;
            continue;
         end
         chk("pmem_exclusive", {255'd0, pmem_read && pmem_write}, 256'd0);
         if (pv_act && !pv_resp)
            chk("pmem_hold", {109'd0, pmem_read, pmem_write, pmem_address,
                              pmem_write ? pmem_wdata : 128'd0}, pv_req);
         if (mem_resp) begin
            n_resp++;
            if (mem_read) chk("rdata_model", {128'd0, mem_rdata}, {128'd0, a_rd(mem_address)});
            else if (mem_write) arch[mem_address] = mem_wdata;
            else chk("resp_without_req", 256'd1, 256'd0);
         end
         if (pmem_resp && pmem_write) begin
            n_pw++;
            last_pw_addr = pmem_address;
            last_pw_data = pmem_wdata;
         end
         if (pmem_resp && pmem_read) n_pr++;
         pv_act  = pmem_read || pmem_write;
         pv_resp = pmem_resp;
         pv_req  = {109'd0, pmem_read, pmem_write, pmem_address, pmem_write ? pmem_wdata : 128'd0};
      end
   end

   // All request tasks start and end at posedge+1.
   task automatic do_write(input lc3b_pmem_addr a, input lc3b_pmem_line d,
                           output int cyc, output bit saw_pmem);
      mem_write = 1'b1; mem_read = 1'b0; mem_address = a; mem_wdata = d;
      cyc = 0; saw_pmem = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_resp) begin
            if (pmem_read || pmem_write) saw_pmem = 1'b1;
            break;
         end
         cyc++;
         if (cyc >= TMO) begin
            chk("write_timeout", 256'd1, 256'd0);
            break;
         end
      end
      @(posedge clk); #1;
      mem_write = 1'b0;
   endtask

   task automatic do_read(input lc3b_pmem_addr a, output lc3b_pmem_line d, output int cyc,
                          output bit saw_pw, output bit saw_pr, output lc3b_pmem_addr pr_a);
      mem_read = 1'b1; mem_write = 1'b0; mem_address = a;
      cyc = 0; saw_pw = 1'b0; saw_pr = 1'b0; pr_a = '0; d = '0;
      forever begin
         @(negedge clk);
         if (pmem_write) saw_pw = 1'b1;
         if (pmem_read) begin saw_pr = 1'b1; pr_a = pmem_address; end
         if (mem_resp) begin d = mem_rdata; break; end
         cyc++;
         if (cyc >= TMO) begin
            chk("read_timeout", 256'd1, 256'd0);
            break;
         end
      end
      @(posedge clk); #1;
      mem_read = 1'b0;
   endtask

   task automatic wait_quiet();
      int q = 0;
      int t = 0;
      while (q < 3) begin
         @(negedge clk);
         if (!pmem_read && !pmem_write) q++; else q = 0;
         t++;
         if (t >= TMO) begin
            chk("quiet_timeout", 256'd1, 256'd0);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   lc3b_pmem_line d1, d2, d3, d4, rd;
   lc3b_pmem_addr pra;
   int cyc, pw0, r0;
   bit sp, spw, spr;

   initial begin
      d1 = {8{16'hd1d1}};
      d2 = {8{16'hd2d2}};
      d3 = {8{16'hd3d3}};
      d4 = {8{16'hd4d4}};
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
      @(negedge clk);
      chk("reset_mem_resp",   {255'd0, mem_resp},   256'd0);
      chk("reset_pmem_read",  {255'd0, pmem_read},  256'd0);
      chk("reset_pmem_write", {255'd0, pmem_write}, 256'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Write capture then idle drain.
      pw0 = n_pw;
      do_write(16'h1230, d1, cyc, sp);
      chk("cap_latency", cyc, 0);
      chk("cap_no_pmem", {255'd0, sp}, 256'd0);
      @(negedge clk);
      @(negedge clk);
      chk("drain_req", {110'd0, pmem_write, pmem_address, pmem_wdata}, {110'd1, 16'h1230, d1});
      wait_quiet();
      chk("drain_count", n_pw - pw0, 1);
      chk("drain_data", {112'd0, last_pw_addr, last_pw_data}, {112'd0, 16'h1230, d1});

      // Forward from the entry.
      do_write(16'h1230, d1, cyc, sp);
      do_read(16'h1230, rd, cyc, spw, spr, pra);
      chk("fwd_latency", cyc, 0);
      chk("fwd_data", {128'd0, rd}, {128'd0, d1});
      chk("fwd_no_pmem_read", {255'd0, spr}, 256'd0);
      wait_quiet();

      // Read miss beats the idle drain.
      pw0 = n_pw;
      do_write(16'h1230, d1, cyc, sp);
      do_read(16'h4560, rd, cyc, spw, spr, pra);
      chk("prio_pmem_read", {239'd0, spr, pra}, {239'd1, 16'h4560});
      chk("prio_no_write", {255'd0, spw}, 256'd0);
      chk("prio_data", {128'd0, rd}, {128'd0, {4{16'h4560, 16'hba9f}}});
      wait_quiet();
      chk("prio_drain_after", {224'd0, n_pw - pw0, last_pw_addr}, {224'd0, 16'd1, 16'h1230});

      // Conflicting write stalls behind the drain.
      do_write(16'h1230, d3, cyc, sp);
      pw0 = n_pw; r0 = n_resp;
      do_write(16'h7770, d4, cyc, sp);
      chk("conflict_stalled", {255'd0, cyc > 0}, 256'd1);
      chk("conflict_drain_first", {112'd0, last_pw_addr, last_pw_data}, {112'd0, 16'h1230, d3});
      @(negedge clk);
      chk("conflict_one_resp", n_resp - r0, 1);
      @(posedge clk); #1;
      wait_quiet();
      chk("conflict_final", {112'd0, last_pw_addr, last_pw_data}, {112'd0, 16'h7770, d4});
      chk("conflict_pw_count", n_pw - pw0, 2);

      // Coalesce two writes to one line.
      pw0 = n_pw;
      do_write(16'h1230, d1, cyc, sp);
      do_write(16'h1230, d2, cyc, sp);
      chk("coalesce_latency", cyc, 0);
      wait_quiet();
      chk("coalesce_count", n_pw - pw0, 1);
      chk("coalesce_data", {128'd0, last_pw_data}, {128'd0, d2});

      // Directed sequence checked against the model.
      do_write(16'h0010, d1, cyc, sp);
      do_read(16'h0010, rd, cyc, spw, spr, pra);
      do_write(16'h0020, d3, cyc, sp);
      do_read(16'h0010, rd, cyc, spw, spr, pra);
      chk("seq_miss_after_drain", {128'd0, rd}, {128'd0, d1});
      do_read(16'h0020, rd, cyc, spw, spr, pra);
      do_read(16'h0030, rd, cyc, spw, spr, pra);
      do_write(16'h0020, d4, cyc, sp);
      wait_quiet();
      do_read(16'h0020, rd, cyc, spw, spr, pra);
      chk("seq_final", {128'd0, rd}, {128'd0, d4});

      // Reset in the middle of a drain.
      do_write(16'h1230, d3, cyc, sp);
      @(negedge clk);
      @(negedge clk);
      chk("mid_drain_active", {255'd0, pmem_write}, 256'd1);
      #1;
      reset = 1'b1;
      arch = pstore;
      #1;
      chk("async_drop", {253'd0, pmem_write, pmem_read, mem_resp}, 256'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      pw0 = n_pw;
      wait_quiet();
      chk("post_reset_no_drain", n_pw - pw0, 0);
      do_read(16'h1230, rd, cyc, spw, spr, pra);
      chk("post_reset_miss", {255'd0, spr}, 256'd1);
      chk("post_reset_data", {128'd0, rd}, {128'd0, d2});
      wait_quiet();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
